// File: rtl/mdu_seq_if.sv
// Request/response bundle between the control FSM and the mdu_seq sequencer.
// The master issues an operation; the slave reports busy, done and the result.
interface mdu_seq_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer borrowing the shared ALU
// for its shift/add and restoring shift/subtract steps.
module mdu_seq #(
    parameter logic [3:0] ALU_ADD = 4'd0,
    parameter logic [3:0] ALU_SUB = 4'd8,
    parameter int         ITERS   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_seq_if.slave    bus,
    input  logic [31:0] alu_out,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    localparam logic [4:0] LAST = 5'(ITERS - 1);

    state_t      state;
    logic [2:0]  f3;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] m;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        neg;
    logic [4:0]  cnt;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;

    logic        is_div;
    logic        x_neg;
    logic        y_neg;
    logic [31:0] x_mag;
    logic [31:0] y_mag;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] rem_sh;
    logic        take;
    logic        carry;
    logic [63:0] prod_fix;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] fix_sel;

    // Operand signedness, magnitudes, special cases and fix-up selection
    always_comb begin
        is_div   = f3[2];
        x_neg    = x[31] & ((f3 == 3'd1) | (f3 == 3'd2)
                          | (f3 == 3'd4) | (f3 == 3'd6));
        y_neg    = y[31] & ((f3 == 3'd1) | (f3 == 3'd4)
                          | (f3 == 3'd6));
        x_mag    = x_neg ? (32'd0 - x) : x;
        y_mag    = y_neg ? (32'd0 - y) : y;
        div_zero = is_div & (y == 32'd0);
        div_ovf  = is_div & ~f3[0] & (x == 32'h8000_0000)
                 & (y == 32'hFFFF_FFFF);
        rem_sh   = {hi[30:0], lo[31]};
        take     = hi[31] | (rem_sh >= m);
        carry    = alu_out < hi;
        prod_fix = neg ? (64'd0 - {hi, lo}) : {hi, lo};
        q_fix    = neg ? (32'd0 - lo) : lo;
        r_fix    = neg ? (32'd0 - hi) : hi;
        case (f3)
            3'd0:    fix_sel = prod_fix[31:0];
            3'd1,
            3'd2,
            3'd3:    fix_sel = prod_fix[63:32];
            3'd4,
            3'd5:    fix_sel = q_fix;
            default: fix_sel = r_fix;
        endcase
    end

    // Shared-ALU request: only driven while iterating, zero otherwise
    always_comb begin
        alu_op = 4'd0;
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        if (state == ITER) begin
            if (is_div) begin
                alu_op = ALU_SUB;
                alu_a  = rem_sh;
                alu_b  = m;
            end else begin
                alu_op = ALU_ADD;
                alu_a  = hi;
                alu_b  = lo[0] ? m : 32'd0;
            end
        end
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            f3       <= 3'd0;
            x        <= 32'd0;
            y        <= 32'd0;
            m        <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            neg      <= 1'b0;
            cnt      <= 5'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        f3     <= bus.funct3;
                        x      <= bus.rs1;
                        y      <= bus.rs2;
                        busy_r <= 1'b1;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    neg <= (f3[2] & f3[1]) ? x_neg : (x_neg ^ y_neg);
                    cnt <= 5'd0;
                    hi  <= 32'd0;
                    m   <= is_div ? y_mag : x_mag;
                    lo  <= is_div ? x_mag : y_mag;
                    if (div_zero) begin
                        result_r <= f3[1] ? x : 32'hFFFF_FFFF;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else if (div_ovf) begin
                        result_r <= f3[1] ? 32'd0 : 32'h8000_0000;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        hi <= take ? alu_out : rem_sh;
                        lo <= {lo[30:0], take};
                    end else begin
                        hi <= {carry, alu_out[31:1]};
                        lo <= {alu_out[0], lo[31:1]};
                    end
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_r <= fix_sel;
                    done_r   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule
